fetch_pc_gen: RTL

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one block-aligned fetch at a time, follows redirects,
// and squashes the in-flight block when a redirect arrives before its response.
module fetch_pc_gen #(
  parameter int                XLEN        = 64,
  parameter int                FETCH_WIDTH = 1,
  parameter logic [XLEN-1:0]   RESET_PC    = '0,
  parameter int                CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_jmp,
  input  logic [XLEN-1:0]        jmp_target,
  input  logic                   fetch_flush,
  input  logic [XLEN-1:0]        pc_from_flush,
  input  logic                   stall,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [XLEN-1:0]        req_addr,
  input  logic                   resp_valid,
  output logic                   fetch_valid,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [FETCH_WIDTH-1:0] lane_mask,
  output logic                   redirect_pending,
  output logic [CNT_W-1:0]       redirect_count
);

  localparam logic [XLEN-1:0] BLK_BYTES  = XLEN'(4 * FETCH_WIDTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(BLK_BYTES - XLEN'(1));
  localparam logic [XLEN-1:0] LANE_MASK  = XLEN'(FETCH_WIDTH - 1);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        pend_target;
  logic                   redirect;
  logic [XLEN-1:0]        target;
  logic                   handshake;
  logic [XLEN-1:0]        lane_idx;
  logic [FETCH_WIDTH-1:0] lane_mask_next;

  assign redirect = is_jmp | fetch_flush;
  assign req_addr = pc & ALIGN_MASK;

  always_comb begin
    target = fetch_flush ? pc_from_flush : jmp_target;
    target[1:0] = 2'b00;
  end

  // Lane index of the first valid instruction within the block.
  always_comb begin
    lane_idx       = (pc >> 2) & LANE_MASK;
    lane_mask_next = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask_next[i] = (XLEN'(i) >= lane_idx);
    end
  end

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    handshake  = 1'b0;
    case (state)
      S_REQ: begin
        req_valid = reset & ~stall;
        handshake = req_valid & req_ready;
        if (handshake) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_REQ;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc               <= RESET_PC;
      pend_target      <= '0;
      redirect_pending <= 1'b0;
      fetch_valid      <= 1'b0;
      fetch_pc         <= '0;
      lane_mask        <= '0;
      redirect_count   <= '0;
    end else begin
      fetch_valid <= 1'b0;
      if (redirect && (redirect_count != '1)) redirect_count <= redirect_count + CNT_W'(1);

      case (state)
        S_REQ: begin
          if (redirect) begin
            // The old request is already accepted, so hold the target until it returns.
            if (handshake) begin
              redirect_pending <= 1'b1;
              pend_target      <= target;
            end else begin
              pc <= target;
            end
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            redirect_pending <= 1'b0;
            if (redirect) begin
              pc <= target;
            end else if (redirect_pending) begin
              pc <= pend_target;
            end else begin
              fetch_valid <= 1'b1;
              fetch_pc    <= pc;
              lane_mask   <= lane_mask_next;
              pc          <= req_addr + BLK_BYTES;
            end
          end else if (redirect) begin
            redirect_pending <= 1'b1;
            pend_target      <= target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
